// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one external memory port between the instruction-fetch requester (IF)
// and the data-memory requester (DM). Only one transaction is outstanding at a
// time. DM has priority, but after MAX_DM_BURST consecutive DM grants while IF
// is waiting, IF is forced to win. The granted request is registered onto the
// ext_* bus, and read data is routed back to whichever requester owns the
// transaction.
//
// Ports:
//   clk, nrst                    clock (rising edge), async active-low reset
//   if_req/if_addr               fetch read request, held until if_gnt
//   if_gnt                       fetch request captured (combinational pulse)
//   if_rvalid/if_rdata           fetch read data return
//   dm_req/dm_we/dm_wstrb/
//   dm_addr/dm_wdata             data request, held until dm_gnt
//   dm_gnt                       data request captured (combinational pulse)
//   dm_rvalid/dm_rdata           data read data return (never for writes)
//   ext_req/ext_we/ext_wstrb/
//   ext_addr/ext_wdata           registered external request
//   ext_ack                      external accepted the request this cycle
//   ext_rvalid/ext_rdata         external read data return
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MAX_DM_BURST = 4
) (
   input  logic          clk,
   input  logic          nrst,
   // instruction fetch side
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   // data memory side
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [3:0]    dm_wstrb,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   // external memory side
   output logic          ext_req,
   output logic          ext_we,
   output logic [3:0]    ext_wstrb,
   output logic [AW-1:0] ext_addr,
   output logic [DW-1:0] ext_wdata,
   input  logic          ext_ack,
   input  logic          ext_rvalid,
   input  logic [DW-1:0] ext_rdata
);

   localparam int            CW        = $clog2(MAX_DM_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DM_BURST);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          owner_dm;    // 1 = DM owns the transaction, 0 = IF
   logic          owner_we;    // owning transaction is a write
   logic [CW-1:0] starve_cnt;  // consecutive DM grants while IF was pending
   logic          starve_max;

   assign starve_max = (starve_cnt == BURST_MAX);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; combinational blocks use blocking (=).
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   // -------------------------------------------------------------------------
   // Next state and grant decode
   // -------------------------------------------------------------------------
   // NOTE: every output of this block is given a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      case (state)
         IDLE: begin
            // Grants are gated by nrst: the state register already sits in
            // IDLE during reset, yet no grant may be reported until release.
            if (dm_req && !(if_req && starve_max)) begin
               dm_gnt    = nrst;
               state_nxt = ISSUE;
            end else if (if_req) begin
               if_gnt    = nrst;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (ext_ack) state_nxt = owner_we ? IDLE : WAIT;
         end
         WAIT: begin
            if (ext_rvalid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // External request, ownership, starvation counter and read return
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ext_req    <= 1'b0;
         ext_we     <= 1'b0;
         ext_wstrb  <= '0;
         ext_addr   <= '0;
         ext_wdata  <= '0;
         owner_dm   <= 1'b0;
         owner_we   <= 1'b0;
         starve_cnt <= '0;
         if_rvalid  <= 1'b0;
         dm_rvalid  <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         // rvalid outputs are single-cycle pulses
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;

         if (dm_gnt) begin
            ext_req   <= 1'b1;
            ext_we    <= dm_we;
            ext_wstrb <= dm_wstrb;
            ext_addr  <= dm_addr;
            ext_wdata <= dm_wdata;
            owner_dm  <= 1'b1;
            owner_we  <= dm_we;
            // Count DM wins only while IF is actually being held off.
            if (!if_req)          starve_cnt <= '0;
            else if (!starve_max) starve_cnt <= starve_cnt + CNT_ONE;
         end else if (if_gnt) begin
            ext_req    <= 1'b1;
            ext_we     <= 1'b0;
            ext_wstrb  <= 4'b1111;
            ext_addr   <= if_addr;
            ext_wdata  <= '0;
            owner_dm   <= 1'b0;
            owner_we   <= 1'b0;
            starve_cnt <= '0;
         end

         // Payload is left in place after the ack; only ext_req drops.
         if (state == ISSUE && ext_ack) ext_req <= 1'b0;

         if (state == WAIT && ext_rvalid) begin
            if (owner_dm) begin
               dm_rdata  <= ext_rdata;
               dm_rvalid <= 1'b1;
            end else begin
               if_rdata  <= ext_rdata;
               if_rvalid <= 1'b1;
            end
         end
      end
   end

endmodule
